// File: rtl/condflow_pkg.sv
// condflow shared types: merge FSM state encoding and
// the arbitration helper used by the two-way merge.
package condflow_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        REQ   = 3'd2,
        RTZ   = 3'd3,
        ACK   = 3'd4
    } state_t;

    // Round-robin pointer value after reset, so the first
    // contention goes to channel 0.
    localparam logic LAST_RST = 1'b1;

    // Winner select: a lone requester wins, contention flips
    // away from whoever was served last.
    function automatic logic pick(
        input logic r0,
        input logic r1,
        input logic last
    );
        if (r0 && r1) begin
            return ~last;
        end
        return r1;
    endfunction

endpackage

// File: rtl/merge2_sync_sync_bit.sv
// Single-bit synchronizer: SYNC-deep flop chain with async
// active-low clear; SYNC=0 makes it a plain wire.
module sync_bit #(
    parameter int SYNC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    generate
        if (SYNC == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign q = d;
        end else begin : g_chain
            logic [SYNC-1:0] chain;

            // shift the asynchronous level through the chain
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    chain <= '0;
                end else begin
                    chain[0] <= d;
                    for (int i = 1; i < SYNC; i++) begin
                        chain[i] <= chain[i-1];
                    end
                end
            end

            assign q = chain[SYNC-1];
        end
    endgenerate

endmodule

// File: rtl/merge2_sync.sv
// Two-way arbitrated four-phase merge with synchronized
// handshakes; every output comes straight from a flop.
module merge2_sync
    import condflow_pkg::*;
#(
    parameter int N    = 1,
    parameter int SYNC = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         r0_i,
    output logic         a0_i,
    input  logic [N-1:0] d0_i,
    input  logic         r1_i,
    output logic         a1_i,
    input  logic [N-1:0] d1_i,
    output logic         r_o,
    input  logic         a_o,
    output logic [N-1:0] d_o,
    output logic         s_o
);

    logic   r0s;
    logic   r1s;
    logic   aos;
    logic   last;
    logic   w;
    logic   rws;
    state_t state;

    sync_bit #(.SYNC(SYNC)) u_sync_r0 (
        .clk (clk),
        .rst (rst),
        .d   (r0_i),
        .q   (r0s)
    );

    sync_bit #(.SYNC(SYNC)) u_sync_r1 (
        .clk (clk),
        .rst (rst),
        .d   (r1_i),
        .q   (r1s)
    );

    sync_bit #(.SYNC(SYNC)) u_sync_ao (
        .clk (clk),
        .rst (rst),
        .d   (a_o),
        .q   (aos)
    );

    // s_o doubles as the latched winner for the whole token
    assign w   = pick(r0s, r1s, last);
    assign rws = s_o ? r1s : r0s;

    // merge handshake sequencer with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            last  <= LAST_RST;
            r_o   <= 1'b0;
            a0_i  <= 1'b0;
            a1_i  <= 1'b0;
            d_o   <= '0;
            s_o   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (r0s || r1s) begin
                        d_o   <= w ? d1_i : d0_i;
                        s_o   <= w;
                        last  <= w;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    r_o   <= 1'b1;
                    state <= REQ;
                end
                REQ: begin
                    if (aos) begin
                        r_o   <= 1'b0;
                        state <= RTZ;
                    end
                end
                RTZ: begin
                    if (!aos) begin
                        if (s_o) begin
                            a1_i <= 1'b1;
                        end else begin
                            a0_i <= 1'b1;
                        end
                        state <= ACK;
                    end
                end
                ACK: begin
                    if (!rws) begin
                        a0_i  <= 1'b0;
                        a1_i  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/merge2_sync.md
Name: merge2_sync

Overview:
- Clocked two-way arbitrated merge. It is the downstream stage of the two-way conditional demux in condflow.
- It consumes the demux's two four-phase bundled-data output channels (channel 0 and channel 1) and recombines them onto one four-phase output channel.
- A side tag reports which input supplied each token.
- Async handshake inputs are synchronized, so the block can hand condflow tokens into clocked logic.

Parameters:
- N, 1, data width per channel (bundled with request).
- SYNC, 2, synchronizer depth on r0_i, r1_i, a_o. 0 means bypass, for when inputs are already clk-synchronous.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous active-low reset (rst=0 => reset).
- r0_i  input  1  channel-0 request (four-phase).
- a0_i  output  1  channel-0 acknowledge.
- d0_i  input  N  channel-0 data, stable while r0_i high.
- r1_i  input  1  channel-1 request.
- a1_i  output  1  channel-1 acknowledge.
- d1_i  input  N  channel-1 data, stable while r1_i high.
- r_o  output  1  merged request.
- a_o  input  1  merged acknowledge.
- d_o  output  N  merged data, registered.
- s_o  output  1  source tag: 0 = channel 0, 1 = channel 1. Bundled with d_o.

Behaviour:
- All outputs are flop-driven, with no combinational paths to outputs (glitch-free for async consumers).
- Reset values: r_o=0, a0_i=0, a1_i=0, d_o=0, s_o=0, state=IDLE, last=1, all synchronizer flops 0. Reset clears these asynchronously.
- Synchronized versions of r0_i, r1_i, a_o are r0s, r1s, aos (each delayed by SYNC edges).
- d0_i/d1_i are sampled unsynchronized. Sampling happens only after the matching rNs is high, so the data is already stable.
- FSM states: IDLE, SETUP, REQ, RTZ, ACK.
  - IDLE: if r0s or r1s is high, pick winner w. With one requester, that requester wins. With both, w = ~last (round-robin; first contention goes to channel 0). On the transition: d_o<=d_w_i, s_o<=w, last<=w. Go to SETUP.
  - SETUP: one cycle so d_o/s_o settle before request. r_o<=1. Go to REQ.
  - REQ: hold r_o=1 until aos=1. Then r_o<=0. Go to RTZ.
  - RTZ: wait aos=0. Then a_w_i<=1. Go to ACK.
  - ACK: hold a_w_i=1 until rws=0. Then a_w_i<=0. Go to IDLE.
- d_o/s_o hold from SETUP entry until the next IDLE->SETUP transition.
- Latency, counting rising edges after the input event:
  - r_w_i rise -> d_o valid at SYNC+1, r_o rise at SYNC+2.
  - a_o rise -> r_o fall at SYNC+1.
  - a_o fall -> a_w_i rise at SYNC+1.
  - r_w_i fall -> a_w_i fall at SYNC+1.
- The losing request stays pending, with no ack. It is served from IDLE immediately after the current cycle completes.
- A new request arriving during SETUP..ACK is not sampled until IDLE.
- A winner request dropping before ack (protocol violation) is ignored: the token still completes and d_o is unchanged. Benches flag it as an error, not a DUT fail.
- a_o rising while in IDLE/SETUP is ignored; REQ sees it once r_o=1.
- rst asserted mid-handshake: all outputs low at once, FSM to IDLE, last=1. The environment must restart the handshake. No token replay.
- a0_i and a1_i are never high together. r_o and any a_k_i are never high together.

Decomposition:
- Package condflow_pkg: state enum (IDLE, SETUP, REQ, RTZ, ACK), 3-bit encoding.
- Sub-module sync_bit #(SYNC): a SYNC-deep flop chain with async active-low reset to 0, pass-through when SYNC=0. Three instances.

Test Plan:
- SYNC=2, N=8. Raise r0_i with d0_i=0xA5. Required: d_o=0xA5, s_o=0 at edge 3; r_o=1 at edge 4. Answer a_o: r_o falls 3 edges after a_o rise; a0_i rises 3 edges after a_o fall; a0_i falls 3 edges after r0_i fall.
- Both requests in the same cycle (d0=0x11, d1=0x22). Required order: 0x11/s_o=0, then 0x22/s_o=1. Repeat: 0x11, then 0x22 again.
- Channel 1 held continuously high while channel 0 toggles. Required: strict alternation of s_o (1,0,1,0...) with no starvation over 100 tokens.
- SYNC=0, random a_o delays of 0–5 cycles, 1000 random tokens. Required: scoreboard order and data match. Output handshake is fully four-phase. Acks stay mutually exclusive.
- Drive rst=0 while in REQ with r_o=1. Required: r_o, a0_i, a1_i low before the next edge. After release, the next contention is won by channel 0.
- Change d0_i after r0_i falls, before the next request. Required: d_o unchanged until the next SETUP.
